countdown_timer_bank: RTL and testbench
=======================================

COUNTDOWN_TIMER_BANK -- requirements
Module: countdown_timer_bank

Interface
REQ-001 The block SHALL have parameters, one per line:
 WIDTH  10  count width in bits; max period 2^WIDTH-1 ticks
 CHANNELS  4  number of independent countdown channels
 TICK_DIV  50_000_000  clk cycles per count tick (1 = every cycle)
REQ-002 The block SHALL have ports, one per line:
 clk  in  1  single clock; all logic on rising edge
 reset  in  1  synchronous, active-high reset
 start  in  CHANNELS  per-channel start/restart strobe
 stop  in  CHANNELS  per-channel abort strobe
 pause  in  CHANNELS  per-channel hold level
 auto_reload  in  CHANNELS  per-channel mode, sampled at start: 0 one-shot, 1 periodic
 load_val  in  CHANNELS*WIDTH  per-channel period; channel i uses bits [i*WIDTH +: WIDTH]
 count  out  CHANNELS*WIDTH  per-channel current value, same packing
 done  out  CHANNELS  level; high while channel is in DONE
 expire  out  CHANNELS  one-cycle pulse on each expiry
 tick  out  1  one-cycle pulse on each prescaler wrap
REQ-003 One clock; reset is synchronous and active-high; clock port named clk, reset port named reset.

Function
REQ-004 The prescaler SHALL count 0..TICK_DIV-1, wrap to 0, and assert tick for the single cycle its value is TICK_DIV-1.
REQ-005 The prescaler SHALL be shared by all channels and cleared only by reset.
REQ-006 Each channel SHALL implement states IDLE, RUN, PAUSED, DONE.
REQ-007 Per-channel priority SHALL be: reset > stop > start > pause > tick.
REQ-008 stop in any state SHALL go to IDLE with count=0, done=0, no expire.
REQ-009 start in any state SHALL latch load_val into count and a reload register, latch auto_reload, and go to RUN; count shows the new value the next cycle.
REQ-010 start with load_val=0 SHALL go straight to DONE with done=1 and a one-cycle expire pulse the next cycle; auto_reload is ignored.
REQ-011 In RUN with pause high, the channel SHALL go to PAUSED; in PAUSED with pause low, it SHALL return to RUN; count does not change in PAUSED.
REQ-012 In RUN with tick high and count>1, count SHALL decrement by 1.
REQ-013 In RUN with tick high and count=1: one-shot SHALL set count=0 and go to DONE; periodic SHALL reload count from the reload register and stay in RUN.
REQ-014 On each case in REQ-013, expire SHALL pulse for exactly one cycle, aligned with the cycle count shows 0 or the reloaded value.
REQ-015 DONE SHALL hold count=0 and done=1 until start, stop or reset.
REQ-016 Count SHALL never wrap below 0 or exceed the latched load value.
REQ-017 Pause in IDLE or DONE SHALL have no effect.
REQ-018 All outputs SHALL be registered; channels SHALL be fully independent apart from the shared tick.

Reset
REQ-019 Reset SHALL force, in the same cycle and whatever the state: prescaler=0, tick=0, all channels IDLE, count=0, done=0, expire=0, reload registers=0.
REQ-020 Reset mid-countdown SHALL discard the channel's state; no expire pulse is produced.

Structure
REQ-021 Shared package timer_pkg SHALL hold the channel state enum (IDLE, RUN, PAUSED, DONE) and the default parameter constants.
REQ-022 Sub-module timer_channel SHALL implement one channel; the top SHALL hold the prescaler and a generate loop of CHANNELS timer_channel instances.

Verification (WIDTH=10, CHANNELS=4, TICK_DIV=4)
REQ-023 Reset -> all count=0, done=0, expire=0, tick=0; tick then pulses every 4th cycle.
REQ-024 One-shot: ch0 start, load_val=3 -> count 3,2,1,0 on successive ticks; one expire pulse; done=1 held for 20 more cycles.
REQ-025 Periodic: ch1 start, load_val=2, auto_reload=1 -> count 2,1,2,1,...; expire pulses every 8 cycles; done stays 0.
REQ-026 Pause: ch2 load 9, pause high at count 5 for 10 ticks -> count holds 5; after release, decrements resume on the next tick.
REQ-027 Collisions: start+stop in the same cycle -> IDLE with count=0. Start with load 0 -> done=1 and one expire next cycle. Restart ch3 at count 4 with load 7 -> count 7 next cycle, no expire.
REQ-028 Reset asserted while ch0 is at count 2 -> count=0, IDLE, no expire, prescaler restarts from 0.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer bank: channel state encoding
// and default parameter values.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } chan_state_e;

    localparam int DEF_WIDTH    = 10;
    localparam int DEF_CHANNELS = 4;
    localparam int DEF_TICK_DIV = 50_000_000;

endpackage

// File: rtl/timer_channel.sv
// One countdown channel: one-shot or periodic down-counter advanced by the
// shared tick, with start/stop/pause control and registered outputs.
module timer_channel
    import timer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             auto_reload,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             done,
    output logic             expire
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    chan_state_e      state;
    logic [WIDTH-1:0] reload;
    logic             periodic;

    // Priority inside one cycle: reset > stop > start > pause > tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            count    <= '0;
            reload   <= '0;
            periodic <= 1'b0;
            done     <= 1'b0;
            expire   <= 1'b0;
        end else begin
            expire <= 1'b0;
            if (stop) begin
                state <= ST_IDLE;
                count <= '0;
                done  <= 1'b0;
            end else if (start) begin
                reload   <= load_val;
                periodic <= auto_reload;
                if (load_val == '0) begin
                    state  <= ST_DONE;
                    count  <= '0;
                    done   <= 1'b1;
                    expire <= 1'b1;
                end else begin
                    state <= ST_RUN;
                    count <= load_val;
                    done  <= 1'b0;
                end
            end else begin
                case (state)
                    ST_RUN: begin
                        if (pause) begin
                            state <= ST_PAUSED;
                        end else if (tick) begin
                            if (count > ONE) begin
                                count <= count - ONE;
                            end else begin
                                // Expiry: reload in periodic mode, otherwise park in DONE.
                                expire <= 1'b1;
                                if (periodic) begin
                                    count <= reload;
                                end else begin
                                    state <= ST_DONE;
                                    count <= '0;
                                    done  <= 1'b1;
                                end
                            end
                        end
                    end
                    ST_PAUSED: begin
                        if (!pause) begin
                            state <= ST_RUN;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/countdown_timer_bank.sv
// Bank of independent countdown channels sharing one prescaler that
// produces the count tick every TICK_DIV clock cycles.
module countdown_timer_bank
    import timer_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       start,
    input  logic [CHANNELS-1:0]       stop,
    input  logic [CHANNELS-1:0]       pause,
    input  logic [CHANNELS-1:0]       auto_reload,
    input  logic [CHANNELS*WIDTH-1:0] load_val,
    output logic [CHANNELS*WIDTH-1:0] count,
    output logic [CHANNELS-1:0]       done,
    output logic [CHANNELS-1:0]       expire,
    output logic                      tick
);

    localparam int             PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  LAST  = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0]  P_ONE = {{(PW-1){1'b0}}, 1'b1};

    logic [PW-1:0] presc;
    logic [PW-1:0] presc_next;

    always_comb begin
        presc_next = (presc == LAST) ? '0 : presc + P_ONE;
    end

    // tick is registered alongside the prescaler so it is high exactly
    // while the prescaler holds TICK_DIV-1.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc <= '0;
            tick  <= 1'b0;
        end else begin
            presc <= presc_next;
            tick  <= (presc_next == LAST);
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        timer_channel #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .tick       (tick),
            .start      (start[g]),
            .stop       (stop[g]),
            .pause      (pause[g]),
            .auto_reload(auto_reload[g]),
            .load_val   (load_val[g*WIDTH +: WIDTH]),
            .count      (count[g*WIDTH +: WIDTH]),
            .done       (done[g]),
            .expire     (expire[g])
        );
    end

endmodule

// File: tb/tb_countdown_timer_bank.sv
// Randomized and directed bench for countdown_timer_bank against a
// rule-level reference model (WIDTH=10, CHANNELS=4, TICK_DIV=4).
module tb_countdown_timer_bank;

    localparam int W  = 10;
    localparam int CH = 4;
    localparam int TD = 4;
    localparam int SW = 1 + CH + CH + CH*W;

    logic              clk;
    logic              reset;
    logic [CH-1:0]     start;
    logic [CH-1:0]     stop;
    logic [CH-1:0]     pause;
    logic [CH-1:0]     auto_reload;
    logic [CH*W-1:0]   load_val;
    logic [CH*W-1:0]   count;
    logic [CH-1:0]     done;
    logic [CH-1:0]     expire;
    logic              tick;

    countdown_timer_bank #(
        .WIDTH(W), .CHANNELS(CH), .TICK_DIV(TD)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause),
        .auto_reload(auto_reload), .load_val(load_val), .count(count),
        .done(done), .expire(expire), .tick(tick)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // reference model: prescaler phase plus per-channel behaviour
    int m_phase;
    bit m_tick;
    int m_cnt [CH];
    int m_rel [CH];
    bit m_per [CH];
    bit m_act [CH];
    bit m_hold[CH];
    bit m_done[CH];
    bit m_exp [CH];

    logic [SW-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s cycle %0d: got 'h%0h, expected 'h%0h", tag, cyc, got, want);
        end
    endtask

    task automatic model_step();
        int lv;
        if (reset) begin
            m_phase = 0;
            m_tick  = 1'b0;
            for (int i = 0; i < CH; i++) begin
                m_cnt[i] = 0; m_rel[i] = 0; m_per[i] = 0;
                m_act[i] = 0; m_hold[i] = 0; m_done[i] = 0; m_exp[i] = 0;
            end
        end else begin
            for (int i = 0; i < CH; i++) begin
                lv = int'(load_val[i*W +: W]);
                m_exp[i] = 1'b0;
                if (stop[i]) begin
                    m_act[i] = 0; m_hold[i] = 0; m_done[i] = 0; m_cnt[i] = 0;
                end else if (start[i]) begin
                    m_rel[i] = lv;
                    m_per[i] = auto_reload[i];
                    m_hold[i] = 0;
                    if (lv == 0) begin
                        m_act[i] = 0; m_done[i] = 1; m_exp[i] = 1; m_cnt[i] = 0;
                    end else begin
                        m_act[i] = 1; m_done[i] = 0; m_cnt[i] = lv;
                    end
                end else if (m_act[i] && m_hold[i]) begin
                    if (!pause[i]) m_hold[i] = 0;
                end else if (m_act[i] && pause[i]) begin
                    m_hold[i] = 1;
                end else if (m_act[i] && m_tick) begin
                    if (m_cnt[i] > 1) begin
                        m_cnt[i] = m_cnt[i] - 1;
                    end else begin
                        m_exp[i] = 1;
                        if (m_per[i]) m_cnt[i] = m_rel[i];
                        else begin
                            m_cnt[i] = 0; m_act[i] = 0; m_done[i] = 1;
                        end
                    end
                end
            end
            m_phase = (m_phase + 1) % TD;
            m_tick  = (m_phase == TD - 1);
        end
    endtask

    task automatic push_expected();
        logic [SW-1:0] e;
        e = '0;
        e[SW-1] = m_tick;
        for (int i = 0; i < CH; i++) begin
            e[CH*W + CH + i] = m_done[i];
            e[CH*W + i]      = m_exp[i];
            e[i*W +: W]      = W'(m_cnt[i]);
        end
        exp_q.push_back(e);
    endtask

    // one clock: model follows the edge, outputs checked on the falling edge
    task automatic cycle();
        logic [SW-1:0] e;
        @(posedge clk);
        model_step();
        push_expected();
        @(negedge clk);
        cyc++;
        e = exp_q.pop_front();
        check("tick",   64'(tick),   64'(e[SW-1]));
        check("done",   64'(done),   64'(e[CH*W+CH +: CH]));
        check("expire", 64'(expire), 64'(e[CH*W +: CH]));
        check("count",  64'(count),  64'(e[CH*W-1:0]));
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        run(2);
        reset = 1'b0;
    endtask

    task automatic start_ch(input int ch, input int v, input bit ar);
        start[ch] = 1'b1;
        auto_reload[ch] = ar;
        load_val[ch*W +: W] = W'(v);
        cycle();
        start[ch] = 1'b0;
    endtask

    task automatic wait_count(input int ch, input int v, input string tag);
        int guard = 0;
        while (int'(count[ch*W +: W]) != v && guard < 200) begin
            cycle();
            guard++;
        end
        check(tag, 64'(count[ch*W +: W]), 64'(v));
    endtask

    initial begin
        reset = 1'b1; start = '0; stop = '0; pause = '0;
        auto_reload = '0; load_val = '0;
        do_reset();
        check("rst_count", 64'(count), 64'd0);
        check("rst_tick",  64'(tick),  64'd0);
        run(12);

        // one-shot, load 3
        start_ch(0, 3, 1'b0);
        run(16 + 20);
        check("oneshot_done", 64'(done[0]), 64'd1);
        check("oneshot_cnt",  64'(count[0 +: W]), 64'd0);

        // periodic, load 2
        start_ch(1, 2, 1'b1);
        run(40);
        check("periodic_done", 64'(done[1]), 64'd0);

        // pause at count 5 for ten ticks
        start_ch(2, 9, 1'b0);
        wait_count(2, 5, "pause_reach");
        pause[2] = 1'b1;
        run(10 * TD);
        check("pause_hold", 64'(count[2*W +: W]), 64'd5);
        pause[2] = 1'b0;
        run(12);

        // start and stop together
        start[3] = 1'b1; stop[3] = 1'b1; load_val[3*W +: W] = 10'd6;
        cycle();
        start[3] = 1'b0; stop[3] = 1'b0;
        check("start_stop", 64'(count[3*W +: W]), 64'd0);

        // zero load
        start_ch(3, 0, 1'b1);
        check("zero_done",   64'(done[3]),   64'd1);
        check("zero_expire", 64'(expire[3]), 64'd1);
        cycle();
        check("zero_expire_end", 64'(expire[3]), 64'd0);

        // restart mid-count
        start_ch(3, 8, 1'b0);
        wait_count(3, 4, "restart_reach");
        start_ch(3, 7, 1'b0);
        check("restart_cnt", 64'(count[3*W +: W]), 64'd7);
        check("restart_exp", 64'(expire[3]), 64'd0);
        run(10);

        // reset mid-countdown
        start_ch(0, 5, 1'b0);
        wait_count(0, 2, "rst_reach");
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("midrst_cnt", 64'(count[0 +: W]), 64'd0);
        check("midrst_exp", 64'(expire), 64'd0);
        run(8);

        // random traffic
        for (int k = 0; k < 1500; k++) begin
            for (int i = 0; i < CH; i++) begin
                start[i] = ($urandom_range(15) == 0);
                stop[i]  = ($urandom_range(40) == 0);
                if ($urandom_range(19) == 0) pause[i] = ~pause[i];
                auto_reload[i] = $urandom_range(1);
                load_val[i*W +: W] = W'($urandom_range(12));
            end
            reset = ($urandom_range(299) == 0);
            cycle();
        end
        start = '0; stop = '0; reset = 1'b0;
        run(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
